axis2fib_txwr: RTL

- Upstream neighbour of the fib2fmac TX controller, on the AXI-Stream side of the TX write FIFOs.
- Accepts frames from a 64-bit AXI4-Stream slave and writes each beat into the data FIFO (wf).
- After the last beat of a frame it writes one byte-count word into the write-count FIFO (wcf).
- The downstream controller only starts a frame when both FIFOs are non-empty, so the count word must never precede its frame's data.

---
 rtl/fib_tx_pkg.sv | 29 ++
 rtl/axis2fib_txwr.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fib_tx_pkg.sv
// Shared types and helpers for the FIB TX write path.
// Holds the write-side state encodings, the byte-count ceiling and tkeep helpers.
package fib_tx_pkg;

   typedef enum logic [1:0] {
      ST_DATA = 2'b01,
      ST_CNT  = 2'b10
   } txwr_state_e;

   localparam logic [15:0] BCNT_SAT = 16'hFFFF;

   function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
      logic [3:0] cnt;
      cnt = '0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, keep[i]};
      end
      return cnt;
   endfunction

   // Legal last-beat keep is a nonzero run of ones starting at bit 0,
   // i.e. keep + 1 is a power of two (FF wraps to 00).
   function automatic logic keep_valid(input logic [7:0] keep);
      logic [7:0] nxt;
      nxt = keep + 8'd1;
      return (keep != 8'd0) && ((keep & nxt) == 8'd0);
   endfunction

endpackage

// File: rtl/axis2fib_txwr.sv
// AXI4-Stream slave that writes frame beats into the TX data FIFO (wf)
// and, after each frame, one byte-count word into the count FIFO (wcf).
// Ports: clk_axis/reset_ (async low); s_axis_* stream slave; wrusedw_wf and
// wrfull_wcf FIFO status; wrreq/datain for wf and wcf; frm_cnt, err_keep, err_ovf.
module axis2fib_txwr
   import fib_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int BCNT_WIDTH = 32,
   parameter int WF_AW      = 9,
   parameter int WF_AFULL   = 508
) (
   input  logic                    clk_axis,
   input  logic                    reset_,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   input  logic [WF_AW-1:0]        wrusedw_wf,
   input  logic                    wrfull_wcf,
   output logic                    wrreq_wf,
   output logic [DATA_WIDTH-1:0]   datain_wf,
   output logic                    wrreq_wcf,
   output logic [BCNT_WIDTH-1:0]   datain_wcf,
   output logic [31:0]             frm_cnt,
   output logic                    err_keep,
   output logic                    err_ovf
);

   txwr_state_e               state_q, state_d;
   logic [15:0]               bcnt_q, bcnt_d;
   logic                      tready_q, tready_d;
   logic                      wrreq_wf_q, wrreq_wf_d;
   logic [DATA_WIDTH-1:0]     datain_wf_q, datain_wf_d;
   logic                      wrreq_wcf_q, wrreq_wcf_d;
   logic [BCNT_WIDTH-1:0]     datain_wcf_q, datain_wcf_d;
   logic [31:0]               frm_cnt_q, frm_cnt_d;
   logic                      err_keep_q, err_keep_d;
   logic                      err_ovf_q, err_ovf_d;

   logic                      accept;
   logic [15:0]               add;
   logic [16:0]               sum;

   assign accept = s_axis_tvalid & tready_q;
   assign add    = s_axis_tlast ? {12'd0, keep_popcount(s_axis_tkeep)}
                                : 16'd8;
   assign sum    = {1'b0, bcnt_q} + {1'b0, add};

   always_comb begin
      state_d      = state_q;
      bcnt_d       = bcnt_q;
      wrreq_wf_d   = 1'b0;
      datain_wf_d  = datain_wf_q;
      wrreq_wcf_d  = 1'b0;
      datain_wcf_d = datain_wcf_q;
      frm_cnt_d    = frm_cnt_q;
      err_keep_d   = err_keep_q;
      err_ovf_d    = err_ovf_q;
      unique case (state_q)
         ST_DATA: begin
            if (accept) begin
               wrreq_wf_d  = 1'b1;
               datain_wf_d = s_axis_tdata;
               if (sum[16]) begin
                  bcnt_d    = BCNT_SAT;
                  err_ovf_d = 1'b1;
               end else begin
                  bcnt_d = sum[15:0];
               end
               if (s_axis_tlast) begin
                  state_d = ST_CNT;
                  if (!keep_valid(s_axis_tkeep)) begin
                     err_keep_d = 1'b1;
                  end
               end
            end
         end
         ST_CNT: begin
            if (!wrfull_wcf) begin
               wrreq_wcf_d  = 1'b1;
               datain_wcf_d = BCNT_WIDTH'({bcnt_q, bcnt_q});
               frm_cnt_d    = frm_cnt_q + 32'd1;
               bcnt_d       = 16'd0;
               state_d      = ST_DATA;
            end
         end
         default: begin
            state_d = ST_DATA;
            bcnt_d  = 16'd0;
         end
      endcase
      // Also held low on the ST_CNT -> ST_DATA cycle, giving the
      // two-cycle gap after tlast that lets the count word land first.
      tready_d = (state_q == ST_DATA) && (state_d == ST_DATA)
               && (wrusedw_wf < WF_AW'(WF_AFULL)) && !wrfull_wcf;
   end

   always_ff @(posedge clk_axis or negedge reset_) begin
      if (!reset_) begin
         state_q      <= ST_DATA;
         bcnt_q       <= '0;
         tready_q     <= 1'b0;
         wrreq_wf_q   <= 1'b0;
         datain_wf_q  <= '0;
         wrreq_wcf_q  <= 1'b0;
         datain_wcf_q <= '0;
         frm_cnt_q    <= '0;
         err_keep_q   <= 1'b0;
         err_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bcnt_q       <= bcnt_d;
         tready_q     <= tready_d;
         wrreq_wf_q   <= wrreq_wf_d;
         datain_wf_q  <= datain_wf_d;
         wrreq_wcf_q  <= wrreq_wcf_d;
         datain_wcf_q <= datain_wcf_d;
         frm_cnt_q    <= frm_cnt_d;
         err_keep_q   <= err_keep_d;
         err_ovf_q    <= err_ovf_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign wrreq_wf      = wrreq_wf_q;
   assign datain_wf     = datain_wf_q;
   assign wrreq_wcf     = wrreq_wcf_q;
   assign datain_wcf    = datain_wcf_q;
   assign frm_cnt       = frm_cnt_q;
   assign err_keep      = err_keep_q;
   assign err_ovf       = err_ovf_q;

endmodule
